// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if
//   Bundles the sample stream, host coefficient-write handshake and the two
//   external RAM ports of fir_mac_seq.
//   slave  : the sequencer side (fir_mac_seq)
//   master : the surroundings (sample source, host, RAM models)
//
//   sample_valid/idata      -> sample strobe and data
//   ready                   <- sequencer idle
//   odata/odata_valid       <- filtered output and its update pulse
//   overrun                 <- sticky dropped-sample flag
//   coef_we/waddr/wdata     -> host coefficient write request (held until wack)
//   coef_wack               <- host write executed this cycle
//   coef_addr/wr/dout       <- coefficient RAM port (shared read/write)
//   coef_rdata              -> coefficient RAM read data, 1-cycle latency
//   smp_addr/we/wdata       <- delay RAM port
//   smp_rdata               -> delay RAM read data, 1-cycle latency
interface fir_mac_seq_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          sample_valid;
    logic [DW-1:0] idata;
    logic          ready;
    logic [DW-1:0] odata;
    logic          odata_valid;
    logic          overrun;
    logic          coef_we;
    logic [AW-1:0] coef_waddr;
    logic [DW-1:0] coef_wdata;
    logic          coef_wack;
    logic [AW-1:0] coef_addr;
    logic          coef_wr;
    logic [DW-1:0] coef_dout;
    logic [DW-1:0] coef_rdata;
    logic [AW-1:0] smp_addr;
    logic          smp_we;
    logic [DW-1:0] smp_wdata;
    logic [DW-1:0] smp_rdata;

    modport slave (
        input  sample_valid, idata, coef_we, coef_waddr, coef_wdata,
               coef_rdata, smp_rdata,
        output ready, odata, odata_valid, overrun, coef_wack,
               coef_addr, coef_wr, coef_dout, smp_addr, smp_we, smp_wdata
    );

    modport master (
        output sample_valid, idata, coef_we, coef_waddr, coef_wdata,
               coef_rdata, smp_rdata,
        input  ready, odata, odata_valid, overrun, coef_wack,
               coef_addr, coef_wr, coef_dout, smp_addr, smp_we, smp_wdata
    );
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq
//   Time-multiplexed FIR: each accepted sample is written into a circular
//   delay RAM, then TAPS multiply-accumulate steps run through one shared
//   multiplier and one rounded, saturated output is produced. The coefficient
//   RAM port is shared with host coefficient writes.
//
//   i_fir_clk : sole clock, rising edge
//   i_nreset  : asynchronous active-low reset
//   fir_bus   : fir_mac_seq_if.slave (sample stream, host writes, RAM ports)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   CLR    | zero the delay RAM, one address per cycle; host writes allowed
//   IDLE   | ready; accept a sample or execute a pending host write
//   WRS    | write latched sample at wr_ptr, clear accumulator
//   RUN    | tap step r_cnt: read coef[i] and delay[wr_ptr-i]
//   DRAIN  | two cycles flushing the pipeline, output on the last edge
module fir_mac_seq #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic        i_fir_clk,
    input  logic        i_nreset,
    fir_mac_seq_if.slave fir_bus
);
    localparam int PW   = 2 * DW;
    localparam int ACCW = 2 * DW + AW;

    localparam logic signed [ACCW-1:0] RND     = ACCW'(1 << (DW - 2));
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_WRS   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_cnt;
    logic [1:0]             r_drain;
    logic [AW-1:0]          r_wr_ptr;
    logic [DW-1:0]          r_sample;
    logic                   r_rd_vld;
    logic signed [PW-1:0]   r_prod;
    logic signed [ACCW-1:0] r_acc;
    logic [DW-1:0]          r_odata;
    logic                   r_odata_valid;
    logic                   r_overrun;

    state_t                 w_next;
    logic                   w_accept;
    logic                   w_host_wr;
    logic                   w_cnt_last;
    logic                   w_drain_done;
    logic                   w_ready;
    logic                   w_smp_we;
    logic [AW-1:0]          w_smp_addr;
    logic [DW-1:0]          w_smp_wdata;
    logic [AW-1:0]          w_coef_addr;
    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_acc_sum;
    logic signed [ACCW-1:0] w_acc_rnd;
    logic signed [ACCW-1:0] w_shift;
    logic [DW-1:0]          w_sat;

    assign w_cnt_last   = &r_cnt;
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain == 2'd0);
    assign w_accept     = (r_state == S_IDLE) && fir_bus.sample_valid;
    // Host writes only own the port while the sequencer is not reading taps,
    // and an accepted sample takes priority over a simultaneous write.
    assign w_host_wr    = fir_bus.coef_we && !w_accept &&
                          ((r_state == S_CLR) || (r_state == S_IDLE));

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_smp_we    = 1'b0;
        w_smp_addr  = r_wr_ptr - r_cnt;
        w_smp_wdata = '0;
        w_coef_addr = r_cnt;
        case (r_state)
            S_CLR: begin
                w_smp_we   = 1'b1;
                w_smp_addr = r_cnt;
                if (w_cnt_last) w_next = S_IDLE;
            end
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) w_next = S_WRS;
            end
            S_WRS: begin
                w_smp_we    = 1'b1;
                w_smp_addr  = r_wr_ptr;
                w_smp_wdata = r_sample;
                w_next      = S_RUN;
            end
            S_RUN: begin
                if (w_cnt_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == 2'd0) w_next = S_IDLE;
            end
            default: w_next = S_CLR;
        endcase
        if (w_host_wr) w_coef_addr = fir_bus.coef_waddr;
    end

    assign w_prod    = $signed(fir_bus.coef_rdata) * $signed(fir_bus.smp_rdata);
    // The final tap's product is still in r_prod on the last DRAIN edge, so
    // the output is taken from the sum including it.
    assign w_acc_sum = r_acc + {{AW{r_prod[PW-1]}}, r_prod};
    assign w_acc_rnd = w_acc_sum + RND;
    assign w_shift   = w_acc_rnd >>> (DW - 1);

    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DW-1:0];
        else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DW-1:0];
    end

    always_ff @(posedge i_fir_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state       <= S_CLR;
            r_cnt         <= '0;
            r_drain       <= '0;
            r_wr_ptr      <= '0;
            r_sample      <= '0;
            r_rd_vld      <= 1'b0;
            r_prod        <= '0;
            r_acc         <= '0;
            r_odata       <= '0;
            r_odata_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_next;

            // Shared up-counter: CLR address and RUN tap index, both wrap to
            // zero after the last address.
            if ((r_state == S_CLR) || (r_state == S_RUN)) r_cnt <= r_cnt + 1'b1;
            else                                          r_cnt <= '0;

            // Drain down-counter, terminal count 0 ends the sample.
            if ((r_state == S_RUN) && w_cnt_last)             r_drain <= 2'd1;
            else if ((r_state == S_DRAIN) && (r_drain != 2'd0)) r_drain <= r_drain - 1'b1;

            if (w_accept) r_sample <= fir_bus.idata;

            r_rd_vld <= (r_state == S_RUN);
            r_prod   <= r_rd_vld ? w_prod : '0;

            if (r_state == S_WRS) r_acc <= '0;
            else                  r_acc <= w_acc_sum;

            r_odata_valid <= 1'b0;
            if (w_drain_done) begin
                r_odata       <= w_sat;
                r_odata_valid <= 1'b1;
                r_wr_ptr      <= r_wr_ptr + 1'b1;
            end

            if (fir_bus.sample_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

    assign fir_bus.ready       = w_ready;
    assign fir_bus.odata       = r_odata;
    assign fir_bus.odata_valid = r_odata_valid;
    assign fir_bus.overrun     = r_overrun;
    assign fir_bus.coef_wack   = w_host_wr;
    assign fir_bus.coef_wr     = w_host_wr;
    assign fir_bus.coef_addr   = w_coef_addr;
    assign fir_bus.coef_dout   = fir_bus.coef_wdata;
    assign fir_bus.smp_addr    = w_smp_addr;
    assign fir_bus.smp_we      = w_smp_we;
    assign fir_bus.smp_wdata   = w_smp_wdata;
endmodule

// File: tb/tb_fir_mac_seq.sv
module tb_fir_mac_seq;
    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int TAPS = 512;
    localparam int LAT  = 516;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic coef_clr = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] coef_mem [TAPS];
    logic [DW-1:0] smp_mem  [TAPS];

    always #5 clk = ~clk;

    fir_mac_seq_if #(.AW(AW), .DW(DW)) bus ();

    fir_mac_seq #(.AW(AW), .DW(DW)) dut (
        .i_fir_clk (clk),
        .i_nreset  (nreset),
        .fir_bus   (bus)
    );

    // Synchronous RAM models, one-cycle read latency.
    always @(posedge clk) begin
        if (coef_clr) for (int k = 0; k < TAPS; k++) coef_mem[k] <= '0;
        if (bus.coef_wr) coef_mem[bus.coef_addr] <= bus.coef_dout;
        bus.coef_rdata <= coef_mem[bus.coef_addr];
        if (bus.smp_we) smp_mem[bus.smp_addr] <= bus.smp_wdata;
        bus.smp_rdata <= smp_mem[bus.smp_addr];
    end

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.coef_we = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (TAPS) @(negedge clk);
    endtask

    task automatic clear_coefs();
        @(negedge clk) coef_clr = 1'b1;
        @(negedge clk) coef_clr = 1'b0;
    endtask

    task automatic host_write(input int addr, input int data);
        bit ok;
        ok = 1'b0;
        bus.coef_we = 1'b1;
        bus.coef_waddr = AW'(addr);
        bus.coef_wdata = DW'(data);
        #1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.coef_wack) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL host_write_ack addr=%0d got no wack, required wack", addr); end
        @(posedge clk); #1 bus.coef_we = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; issues immediately if ready is already high.
    task automatic send_sample(input int x, output logic signed [DW-1:0] y, output int lat);
        bit ok;
        ok = 1'b0; y = '0; lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout got ready=0, required 1");
            return;
        end
        bus.sample_valid = 1'b1;
        bus.idata = DW'(x);
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.odata_valid) begin y = bus.odata; return; end
            @(posedge clk);
            lat++;
        end
        checks++; errors++;
        lat = -1;
        $display("FAIL odata_valid_timeout got none, required pulse");
    endtask

    task automatic test_reset();
        int bad;
        nreset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.idata = '0;
        bus.coef_we = 1'b0;
        bus.coef_waddr = '0;
        bus.coef_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.odata !== 16'h0) begin errors++; $display("FAIL rst_odata got=%0d exp=0", bus.odata); end
        checks++; if (bus.odata_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.coef_wack !== 1'b0) begin
            errors++; $display("FAIL rst_flags got v=%b ovr=%b wack=%b exp 0 0 0", bus.odata_valid, bus.overrun, bus.coef_wack);
        end
        nreset = 1'b1;
        bad = 0;
        #1;
        for (int c = 0; c < TAPS; c++) begin
            if (bus.smp_we !== 1'b1 || bus.smp_addr !== AW'(c) || bus.smp_wdata !== 16'h0 || bus.ready !== 1'b0) begin
                if (bad == 0) $display("FAIL clr_seq cycle=%0d got we=%b addr=%0d data=%0d rdy=%b exp we=1 addr=%0d data=0 rdy=0",
                                       c, bus.smp_we, bus.smp_addr, bus.smp_wdata, bus.ready, c);
                bad++;
            end
            @(negedge clk); #1;
        end
        checks++; if (bad != 0) errors++;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clr_done_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.smp_we !== 1'b0) begin errors++; $display("FAIL idle_smp_we got=%b exp=0", bus.smp_we); end
        checks++; if (bus.odata !== 16'h0 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL clr_done_out got odata=%0d ovr=%b exp 0 0", bus.odata, bus.overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_impulse();
        logic signed [DW-1:0] y;
        int lat;
        do_reset();
        clear_coefs();
        host_write(0, 16384);
        send_sample(20000, y, lat);
        checks++; if (y !== 16'sd10000) begin errors++; $display("FAIL impulse_out got=%0d exp=10000", y); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL impulse_latency got=%0d exp=%0d", lat, LAT); end
        // Back to back: issued in the same cycle as odata_valid.
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus.ready); end
        send_sample(0, y, lat);
        checks++; if (y !== 16'sd0) begin errors++; $display("FAIL impulse_zero got=%0d exp=0", y); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
        send_sample(-3, y, lat);
        checks++; if (y !== -16'sd1) begin errors++; $display("FAIL round_neg got=%0d exp=-1", y); end
        send_sample(1, y, lat);
        checks++; if (y !== 16'sd1) begin errors++; $display("FAIL round_half got=%0d exp=1", y); end
    endtask

    task automatic test_delay_tap();
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] exp_out [4];
        int xs [4];
        int lat;
        xs = '{100, 200, 300, 400};
        exp_out = '{16'sd0, 16'sd0, 16'sd0, 16'sd100};
        do_reset();
        clear_coefs();
        host_write(3, 32767);
        for (int n = 0; n < 4; n++) begin
            send_sample(xs[n], y, lat);
            checks++; if (y !== exp_out[n]) begin errors++; $display("FAIL delay_tap_out%0d got=%0d exp=%0d", n + 1, y, exp_out[n]); end
        end
    endtask

    task automatic test_saturation();
        logic signed [DW-1:0] y;
        int lat;
        do_reset();
        clear_coefs();
        for (int k = 0; k < 4; k++) host_write(k, 32767);
        send_sample(32767, y, lat);
        checks++; if (y !== 16'sd32766) begin errors++; $display("FAIL sat_first got=%0d exp=32766", y); end
        repeat (3) send_sample(32767, y, lat);
        checks++; if (y !== 16'sd32767) begin errors++; $display("FAIL sat_pos got=%0d exp=32767", y); end
        repeat (4) send_sample(-32768, y, lat);
        checks++; if (y !== -16'sd32768) begin errors++; $display("FAIL sat_neg got=%0d exp=-32768", y); end
    endtask

    task automatic test_overrun_arb();
        logic signed [DW-1:0] y;
        int lat;
        bit early;
        bit seen;
        do_reset();
        clear_coefs();
        host_write(0, 16384);
        bus.sample_valid = 1'b1;
        bus.idata = 16'd1000;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        bus.sample_valid = 1'b1;
        bus.idata = 16'd7777;
        bus.coef_we = 1'b1;
        bus.coef_waddr = 9'd1;
        bus.coef_wdata = 16'd16384;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
        lat = 51; early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.odata_valid) begin seen = 1'b1; break; end
            if (bus.coef_wack) early = 1'b1;
            @(posedge clk);
            lat++;
        end
        checks++; if (!seen || lat != LAT) begin errors++; $display("FAIL overrun_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (bus.odata !== 16'd500) begin errors++; $display("FAIL overrun_out got=%0d exp=500", $signed(bus.odata)); end
        checks++; if (bus.coef_wack !== 1'b1 || early) begin
            errors++; $display("FAIL wack_first_idle got wack=%b early=%b exp wack=1 early=0", bus.coef_wack, early);
        end
        @(posedge clk); #1 bus.coef_we = 1'b0;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.idata = 16'd2000;
        bus.coef_we = 1'b1;
        bus.coef_waddr = 9'd2;
        bus.coef_wdata = 16'd16384;
        #1;
        checks++; if (bus.coef_wack !== 1'b0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL coincident_wack got wack=%b rdy=%b exp wack=0 rdy=1", bus.coef_wack, bus.ready);
        end
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        lat = 1; early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.odata_valid) begin seen = 1'b1; break; end
            if (bus.coef_wack) early = 1'b1;
            @(posedge clk);
            lat++;
        end
        checks++; if (!seen || bus.odata !== 16'd1500) begin errors++; $display("FAIL coincident_out got=%0d exp=1500", $signed(bus.odata)); end
        checks++; if (bus.coef_wack !== 1'b1 || early) begin
            errors++; $display("FAIL deferred_wack got wack=%b early=%b exp wack=1 early=0", bus.coef_wack, early);
        end
        @(posedge clk); #1 bus.coef_we = 1'b0;
        @(negedge clk);
        send_sample(0, y, lat);
        checks++; if (y !== 16'sd1500) begin errors++; $display("FAIL written_coefs got=%0d exp=1500", y); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_reset_mid_run();
        logic signed [DW-1:0] y;
        int lat;
        int bad;
        bit vld;
        // Coefficients 0..2 are 16384 from the previous test; odata=1500, overrun=1.
        bus.sample_valid = 1'b1;
        bus.idata = 16'd5000;
        @(posedge clk); #1 bus.sample_valid = 1'b0;
        repeat (201) @(posedge clk);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        checks++; if (bus.odata !== 16'h0 || bus.odata_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_odata got=%0d v=%b exp 0 0", bus.odata, bus.odata_valid);
        end
        checks++; if (bus.overrun !== 1'b0 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got ovr=%b rdy=%b exp 0 0", bus.overrun, bus.ready);
        end
        checks++; if (bus.smp_we !== 1'b1 || bus.smp_addr !== 9'd0) begin
            errors++; $display("FAIL midrst_clr got we=%b addr=%0d exp 1 0", bus.smp_we, bus.smp_addr);
        end
        @(negedge clk);
        nreset = 1'b1;
        #1;
        bad = 0; vld = 1'b0;
        for (int c = 0; c < TAPS; c++) begin
            if (bus.smp_we !== 1'b1 || bus.smp_addr !== AW'(c)) begin
                if (bad == 0) $display("FAIL midrst_clr_seq cycle=%0d got we=%b addr=%0d exp we=1 addr=%0d", c, bus.smp_we, bus.smp_addr, c);
                bad++;
            end
            if (bus.odata_valid) vld = 1'b1;
            @(negedge clk); #1;
        end
        checks++; if (bad != 0) errors++;
        checks++; if (vld) begin errors++; $display("FAIL midrst_no_valid got odata_valid=1 exp 0"); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.ready); end
        @(negedge clk);
        send_sample(0, y, lat);
        checks++; if (y !== 16'sd0) begin errors++; $display("FAIL midrst_history got=%0d exp=0", y); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_delay_tap();
        test_saturation();
        test_overrun_arb();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no completion, required finish");
        $fatal(1);
    end
endmodule
